cmd_framer: RTL and testbench
=============================

Name: cmd_framer

Overview:
- Upstream stage of the command-path serializer in the SD host CMD path.
- Accepts a command index and 32-bit argument, then computes CRC7 bit-serially over the 40-bit header.
- Assembles the 48-bit SD command frame and hands it to the serializer with an enable/load handshake.
- Reports completion when the serializer signals complete.

Parameters:
- CRC_POLY, 7'b0001001: CRC7 generator polynomial (x^7+x^3+1), low 7 coefficients.
- TX_BIT, 1'b1: transmission bit placed at frame[46] (1 = host to card).
- TIMEOUT_CYCLES, 128: maximum cycles in WAIT before error. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- cmd_index  input  6  command index, latched on an accepted start.
- cmd_arg  input  32  command argument, latched on an accepted start.
- ser_complete  input  1  serializer complete flag.
- frame  output  48  assembled frame to the serializer `in`.
- ser_enable  output  1  drives the serializer enable.
- ser_load  output  1  one-cycle pulse; restarts the serializer counter (drives its reset).
- crc7  output  7  CRC of the current/last frame.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset (reset=0, async): state=IDLE. frame=0, crc7=0, ser_enable=0, ser_load=0, busy=0, done=0, bit counter=0, internal header=0.
- Header layout (40 bits): {1'b0, TX_BIT, cmd_index, cmd_arg}, MSB first.
- Frame layout: {header, crc7, 1'b1}. frame[47]=0 (start bit), frame[0]=1 (end bit).
- State IDLE:
  - start=1 latches header, clears CRC register and counter, goes to CRC.
  - start=0: stay in IDLE.
- State CRC: one header bit per cycle, MSB first, 40 cycles (counter 0..39).
  - fb = crc[6] ^ bit.
  - crc = {crc[5:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - After bit 39, go to LOAD. First-bit to LOAD latency is exactly 40 cycles after the start-accept edge.
- State LOAD (1 cycle):
  - frame and crc7 update.
  - ser_load=1, ser_enable=1.
  - Next state WAIT.
- State WAIT:
  - ser_enable=1, ser_load=0.
  - ser_complete is ignored in the first WAIT cycle, which guards against a stale complete flag.
  - ser_complete=1 afterwards → DONE.
- State DONE (1 cycle): done=1, ser_enable=0, then IDLE.
- frame and crc7 hold their value until the next LOAD.
- start while busy=1 is ignored entirely; inputs are not relatched.
- start in the cycle DONE→IDLE is ignored. start is accepted from the first IDLE cycle.
- cmd_index and cmd_arg changes after acceptance have no effect on the frame in flight.
- reset mid-operation: immediate return to reset values. No done pulse; the partial CRC is discarded.
- Total start-accept to done: 40 + 1 + N_wait + 1 cycles, where N_wait ≥ 2.

Optional Feature:
- Macro CMD_FRAMER_TIMEOUT_EN.
- Defined:
  - Adds output port error (1 bit, reset 0) and a WAIT-cycle counter.
  - When the counter reaches TIMEOUT_CYCLES without ser_complete: go to DONE with done=1 and error=1 in the same cycle.
  - error holds until the next accepted start clears it.
- Not defined:
  - No error port and no counter.
  - WAIT lasts indefinitely until ser_complete.

Test Plan:
- CMD0, arg 0x00000000: start pulse → after 40 cycles crc7=7'h4A, frame=48'h400000000095, single ser_load pulse.
- CMD8, arg 0x000001AA → crc7=7'h43, frame=48'h48000001AA87. With a serializer model asserting complete 48 cycles after load, done pulses once and busy falls with it.
- CMD17, arg 0x00000000 → frame=48'h510000000055. Start pulses held during CRC/WAIT are ignored: no relatch, exactly one done.
- Reset low at CRC bit 20 → all outputs 0 immediately, no done. A fresh CMD0 afterwards still yields 48'h400000000095.
- Back-to-back: start asserted continuously → second frame's CRC begins the cycle after IDLE is re-entered. Both frames are correct, and ser_enable is low for at least one cycle between them.
- With CMD_FRAMER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ser_complete tied 0 → done=1 and error=1 16 WAIT cycles after LOAD. The next start clears error.

Source files
------------

// File: rtl/cmd_framer.sv
// -----------------------------------------------------------------------------
// cmd_framer
// Upstream stage of the SD host CMD-path serializer. It latches a command
// index and 32-bit argument, computes CRC7 one header bit per cycle, assembles
// the 48-bit SD command frame and hands it to the serializer with a
// load/enable handshake. It reports completion once the serializer signals
// complete.
//
// Optional build macro: CMD_FRAMER_TIMEOUT_EN
//   When this macro is defined, an `error` output and a WAIT-cycle counter are
//   added. If the serializer never completes, WAIT ends after TIMEOUT_CYCLES
//   cycles with done=1 and error=1.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   start        in   1   request pulse, sampled only in IDLE
//   cmd_index    in   6   command index, latched on accepted start
//   cmd_arg      in  32   command argument, latched on accepted start
//   ser_complete in   1   serializer complete flag
//   frame        out 48   {0, TX_BIT, index, arg, crc7, 1} to the serializer
//   ser_enable   out  1   serializer enable (LOAD and WAIT)
//   ser_load     out  1   one-cycle pulse restarting the serializer
//   crc7         out  7   CRC of the current/last frame
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle end-of-transfer pulse
//   error        out  1   (CMD_FRAMER_TIMEOUT_EN only) WAIT timed out
// -----------------------------------------------------------------------------
module cmd_framer #(
  parameter logic [6:0]  CRC_POLY       = 7'b0001001,
  parameter logic        TX_BIT         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        ser_complete,
  output logic [47:0] frame,
  output logic        ser_enable,
  output logic        ser_load,
  output logic [6:0]  crc7,
  output logic        busy,
  output logic        done
`ifdef CMD_FRAMER_TIMEOUT_EN
  ,
  output logic        error
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CRC  = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // One step of the bit-serial CRC7 LFSR.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[6] ^ bit_in;
    return {crc_in[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'd0);
  endfunction

  state_e      state_q, state_d;
  logic [39:0] hdr_q, hdr_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] frame_q, frame_d;
  logic [6:0]  crc7_q, crc7_d;
  logic        wait_first_q, wait_first_d;
  logic        ser_enable_q, ser_enable_d;
  logic        ser_load_q, ser_load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [6:0]  crc_step_s;

`ifdef CMD_FRAMER_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           error_q, error_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

  // Header is consumed MSB first; bit index counts down from 39.
  assign crc_step_s = crc7_step(crc_q, hdr_q[6'd39 - cnt_q]);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    crc7_d       = crc7_q;
    wait_first_d = 1'b0;
`ifdef CMD_FRAMER_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    error_d      = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hdr_d   = {1'b0, TX_BIT, cmd_index, cmd_arg};
          crc_d   = 7'd0;
          cnt_d   = 6'd0;
          state_d = S_CRC;
`ifdef CMD_FRAMER_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CRC: begin
        crc_d = crc_step_s;
        if (cnt_q == 6'd39) begin
          // Final CRC is folded straight into the frame so it is valid while
          // ser_load is high.
          frame_d = {hdr_q, crc_step_s, 1'b1};
          crc7_d  = crc_step_s;
          cnt_d   = 6'd0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_LOAD: begin
        wait_first_d = 1'b1;
`ifdef CMD_FRAMER_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle ignores complete: it may be stale from the
        // previous transfer.
        if (!wait_first_q && ser_complete) begin
          state_d = S_DONE;
`ifdef CMD_FRAMER_TIMEOUT_EN
        end else if (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
`else
        end else begin
          state_d = S_WAIT;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered and follow the state being entered.
    ser_load_d   = (state_d == S_LOAD);
    ser_enable_d = (state_d == S_LOAD) || (state_d == S_WAIT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hdr_q        <= 40'd0;
      crc_q        <= 7'd0;
      cnt_q        <= 6'd0;
      frame_q      <= 48'd0;
      crc7_q       <= 7'd0;
      wait_first_q <= 1'b0;
      ser_enable_q <= 1'b0;
      ser_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CMD_FRAMER_TIMEOUT_EN
      wait_cnt_q   <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      crc7_q       <= crc7_d;
      wait_first_q <= wait_first_d;
      ser_enable_q <= ser_enable_d;
      ser_load_q   <= ser_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CMD_FRAMER_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  assign frame      = frame_q;
  assign crc7       = crc7_q;
  assign ser_enable = ser_enable_q;
  assign ser_load   = ser_load_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CMD_FRAMER_TIMEOUT_EN
  assign error      = error_q;
`endif

endmodule

// File: tb/tb_cmd_framer.sv
// -----------------------------------------------------------------------------
// tb_cmd_framer
// Directed plus randomized bench for cmd_framer. Expected frames come from a
// CRC7 computed by polynomial long division of the header; expected done
// latency comes from the transfer timing rules.
// -----------------------------------------------------------------------------
module tb_cmd_framer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ser_complete;
  logic [47:0] frame;
  logic        ser_enable;
  logic        ser_load;
  logic [6:0]  crc7;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

`ifdef CMD_FRAMER_TIMEOUT_EN
  localparam int TMO = 16;
  logic error;
  cmd_framer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .ser_complete(ser_complete), .frame(frame),
    .ser_enable(ser_enable), .ser_load(ser_load), .crc7(crc7),
    .busy(busy), .done(done), .error(error)
  );
`else
  cmd_framer dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .ser_complete(ser_complete), .frame(frame),
    .ser_enable(ser_enable), .ser_load(ser_load), .crc7(crc7),
    .busy(busy), .done(done)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC7 as the remainder of (header * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc(input logic [39:0] hdr);
    logic [46:0] r;
    r = {hdr, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // One full transfer. d = cycles after the load cycle at which the
  // serializer raises complete; hold keeps start high throughout.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input int d, input bit hold, input string tag);
    logic [39:0] hdr;
    logic [6:0]  exp_crc;
    logic [47:0] exp_f;
    int          loads;
    int          n;
    int          exp_n;
    bit          exp_err;
    bit          en_ok;
    hdr     = {1'b0, 1'b1, idx, arg};
    exp_crc = ref_crc(hdr);
    exp_f   = {hdr, exp_crc, 1'b1};
    exp_n   = ((d < 2) ? 2 : d) + 1;
    exp_err = 1'b0;
`ifdef CMD_FRAMER_TIMEOUT_EN
    if (exp_n > TMO + 1) begin
      exp_n   = TMO + 1;
      exp_err = 1'b1;
    end
`endif
    loads = 0;
    en_ok = 1'b1;

    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    tick();
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
`ifdef CMD_FRAMER_TIMEOUT_EN
    check({tag, " error_cleared"}, 64'(error), 64'd0);
`endif
    if (!hold) start = 1'b0;

    // Scramble inputs and throw stray start pulses while the CRC runs.
    for (int i = 0; i < 39; i++) begin
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      if (!hold) start = (i == 10);
      tick();
      loads += int'(ser_load);
    end
    if (!hold) start = 1'b0;
    check({tag, " no_early_load"}, 64'(loads), 64'd0);

    tick();
    check({tag, " ser_load"}, 64'(ser_load), 64'd1);
    check({tag, " ser_enable_load"}, 64'(ser_enable), 64'd1);
    check({tag, " frame"}, 64'(frame), 64'(exp_f));
    check({tag, " crc7"}, 64'(crc7), 64'(exp_crc));
    loads += int'(ser_load);

    n = 0;
    while (done !== 1'b1 && n < d + 10) begin
      if (n == d) ser_complete = 1'b1;
      if (!hold) start = (n == 1);
      tick();
      n++;
      loads += int'(ser_load);
      if (done !== 1'b1 && ser_enable !== 1'b1) en_ok = 1'b0;
    end
    check({tag, " done_latency"}, 64'(n), 64'(exp_n));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " enable_in_wait"}, 64'(en_ok), 64'd1);
    check({tag, " enable_off_done"}, 64'(ser_enable), 64'd0);
`ifdef CMD_FRAMER_TIMEOUT_EN
    check({tag, " error"}, 64'(error), 64'(exp_err));
`else
    check({tag, " timeout_unused"}, 64'(exp_err), 64'(done ^ 1'b1));
`endif

    ser_complete = 1'b0;
    start        = hold;
    cmd_index    = 6'($urandom);
    tick();
    check({tag, " done_single"}, 64'(done), 64'd0);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " idle_enable"}, 64'(ser_enable), 64'd0);
    check({tag, " frame_hold"}, 64'(frame), 64'(exp_f));
    check({tag, " load_count"}, 64'(loads), 64'd1);
`ifdef CMD_FRAMER_TIMEOUT_EN
    check({tag, " error_hold"}, 64'(error), 64'(exp_err));
`endif
  endtask

  initial begin
    int dones;
    int loads;
    reset        = 1'b0;
    start        = 1'b0;
    ser_complete = 1'b0;
    cmd_index    = 6'd0;
    cmd_arg      = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst frame", 64'(frame), 64'd0);
    check("rst crc7", 64'(crc7), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ser_enable", 64'(ser_enable), 64'd0);
    check("rst ser_load", 64'(ser_load), 64'd0);
    reset = 1'b1;
    tick();

    // Known SD command frames.
    run_frame(6'd0, 32'h0000_0000, 48, 1'b0, "cmd0");
    check("cmd0 const_frame", 64'(frame), 64'h4000_0000_0095);
    check("cmd0 const_crc", 64'(crc7), 64'h4A);
    run_frame(6'd8, 32'h0000_01AA, 48, 1'b0, "cmd8");
    check("cmd8 const_frame", 64'(frame), 64'h4800_0001_AA87);
    check("cmd8 const_crc", 64'(crc7), 64'h43);
    // Complete already high at load: minimum WAIT length.
    ser_complete = 1'b0;
    run_frame(6'd17, 32'h0000_0000, 0, 1'b0, "cmd17");
    check("cmd17 const_frame", 64'(frame), 64'h5100_0000_0055);

    // Reset in the middle of the CRC phase.
    cmd_index = 6'd5;
    cmd_arg   = $urandom;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    #1;
    check("midrst frame", 64'(frame), 64'd0);
    check("midrst crc7", 64'(crc7), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst enable", 64'(ser_enable), 64'd0);
    check("midrst load", 64'(ser_load), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    tick();
    reset = 1'b1;
    dones = 0;
    loads = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      dones += int'(done);
      loads += int'(ser_load);
    end
    check("midrst no_done", 64'(dones), 64'd0);
    check("midrst no_load", 64'(loads), 64'd0);
    check("midrst idle", 64'(busy), 64'd0);
    run_frame(6'd0, 32'h0000_0000, 1, 1'b0, "post_rst_cmd0");
    check("post_rst const_frame", 64'(frame), 64'h4000_0000_0095);

    // Back-to-back with start held high.
    run_frame(6'($urandom), $urandom, 2, 1'b1, "b2b0");
    run_frame(6'($urandom), $urandom, 3, 1'b1, "b2b1");
    run_frame(6'($urandom), $urandom, 5, 1'b1, "b2b2");
    start = 1'b0;
    tick();

    // Randomized commands and serializer delays.
    for (int k = 0; k < 6; k++) begin
      run_frame(6'($urandom), $urandom, int'($urandom_range(60, 0)), 1'b0, "rand");
    end

`ifdef CMD_FRAMER_TIMEOUT_EN
    // Serializer never completes, then the next start clears error.
    run_frame(6'd1, 32'hDEAD_BEEF, 1000, 1'b0, "timeout");
    run_frame(6'd2, 32'h1234_5678, 4, 1'b0, "after_timeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
